// File: rtl/cosim_trace_serializer_pkg.sv
// Shared record type and helpers for the multi-lane commit-trace serializer.
// Field widths here must match the XLEN/ILEN parameters used on the serializer.
package cosim_trace_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [2:0] PRIV_U = 3'd0;
    localparam logic [2:0] PRIV_S = 3'd1;
    localparam logic [2:0] PRIV_M = 3'd3;

    typedef struct packed {
        logic [63:0]     cycle;
        logic [2:0]      lane;
        logic [XLEN-1:0] iaddr;
        logic [ILEN-1:0] insn;
        logic            exception;
        logic            interrupt;
        logic [XLEN-1:0] cause;
        logic            has_wdata;
        logic [XLEN-1:0] wdata;
        logic [2:0]      priv;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // A lane carries a record if it retired, trapped, or reports any cause.
    function automatic logic is_active(input logic            valid,
                                       input logic            exception,
                                       input logic [XLEN-1:0] cause);
        return valid | exception | (|cause);
    endfunction

endpackage

// File: rtl/cosim_trace_serializer_compactor.sv
// Lane compactor: active mask -> per-lane slot offset (exclusive prefix sum) and active count.
// Latency: combinational. Backpressure: none.
// Offsets of inactive lanes are don't-care.
module trace_lane_compactor #(
    parameter int NLANES = 2,
    parameter int OFFW   = $clog2(NLANES + 1)
) (
    input  logic [NLANES-1:0]      act_i,
    output logic [NLANES*OFFW-1:0] offset_o,
    output logic [OFFW-1:0]        n_act_o
);

    always_comb begin
        logic [OFFW-1:0] run;
        run      = '0;
        offset_o = '0;
        for (int i = 0; i < NLANES; i++) begin
            offset_o[i*OFFW +: OFFW] = run;
            run = run + OFFW'(act_i[i]);
        end
        n_act_o = run;
    end

endmodule

// File: rtl/cosim_trace_serializer.sv
// Multi-lane commit-trace capture: compacts active lanes into a FIFO, drains one record per cycle.
// Latency: 1 cycle capture-to-out_rec. Backpressure: out_ready holds head; full FIFO drops whole group,
// counted in drop_count/overflow; stall_req is an advisory early warning.
module cosim_trace_serializer #(
    parameter int NLANES   = 2,
    parameter int XLEN     = 64,
    parameter int ILEN     = 32,
    parameter int DEPTH    = 16,
    parameter int STALL_TH = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [63:0]                      cycle,
    input  logic [NLANES-1:0]                tr_valid,
    input  logic [NLANES-1:0]                tr_exception,
    input  logic [NLANES-1:0]                tr_interrupt,
    input  logic [NLANES-1:0]                tr_has_wdata,
    input  logic [NLANES*XLEN-1:0]           tr_iaddr,
    input  logic [NLANES*ILEN-1:0]           tr_insn,
    input  logic [NLANES*XLEN-1:0]           tr_cause,
    input  logic [NLANES*XLEN-1:0]           tr_wdata,
    input  logic [NLANES*3-1:0]              tr_priv,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [cosim_trace_pkg::REC_W-1:0] out_rec,
    output logic                             stall_req,
    output logic                             overflow,
    output logic [31:0]                      drop_count
);
    import cosim_trace_pkg::*;

    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam int          OFFW      = $clog2(NLANES + 1);
    localparam int unsigned STALL_LIM = (STALL_TH * NLANES) / 4;

    logic [NLANES-1:0]      act;
    trace_rec_t             lane_rec [NLANES];
    logic [NLANES*OFFW-1:0] lane_off;
    logic [OFFW-1:0]        n_act;

    logic [REC_W-1:0]       mem [DEPTH];

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   stall_q, stall_d;
    logic                   overflow_q, overflow_d;
    logic [31:0]            drop_count_q, drop_count_d;

    logic [CW-1:0]          free_now;
    logic [CW-1:0]          free_next;
    logic [32:0]            drop_sum;
    logic                   accept;
    logic                   drop;
    logic                   pop;

    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            act[i]                 = is_active(tr_valid[i], tr_exception[i], tr_cause[i*XLEN +: XLEN]);
            lane_rec[i]            = '0;
            lane_rec[i].cycle      = cycle;
            lane_rec[i].lane       = 3'(i);
            lane_rec[i].iaddr      = tr_iaddr[i*XLEN +: XLEN];
            lane_rec[i].insn       = tr_insn[i*ILEN +: ILEN];
            lane_rec[i].exception  = tr_exception[i];
            lane_rec[i].interrupt  = tr_interrupt[i];
            lane_rec[i].cause      = tr_cause[i*XLEN +: XLEN];
            lane_rec[i].has_wdata  = tr_has_wdata[i];
            lane_rec[i].wdata      = tr_wdata[i*XLEN +: XLEN];
            lane_rec[i].priv       = tr_priv[i*3 +: 3];
        end
    end

    trace_lane_compactor #(
        .NLANES (NLANES),
        .OFFW   (OFFW)
    ) u_compactor (
        .act_i    (act),
        .offset_o (lane_off),
        .n_act_o  (n_act)
    );

    assign out_valid = (count_q != '0);
    assign out_rec   = mem[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    // Room is judged on the registered count only; a same-cycle pop does not make space.
    assign free_now  = CW'(DEPTH) - count_q;
    assign accept    = (n_act != '0) && (CW'(n_act) <= free_now);
    assign drop      = (n_act != '0) && !accept;
    assign drop_sum  = {1'b0, drop_count_q} + 33'(n_act);

    always_comb begin
        count_d      = count_q + (accept ? CW'(n_act) : '0) - CW'(pop);
        wr_ptr_d     = accept ? wr_ptr_q + AW'(n_act) : wr_ptr_q;
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop) begin
            drop_count_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
        free_next    = CW'(DEPTH) - count_d;
        stall_d      = 32'(free_next) < STALL_LIM;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stall_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            stall_q      <= stall_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NLANES; i++) begin
            if (accept && act[i]) begin
                mem[wr_ptr_q + AW'(lane_off[i*OFFW +: OFFW])] <= lane_rec[i];
            end
        end
    end

    assign stall_req  = stall_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_cosim_trace_serializer.sv
// Bench for cosim_trace_serializer: directed scenarios plus randomized traffic against a queue model.
module tb_cosim_trace_serializer;
    import cosim_trace_pkg::*;

    localparam int NL    = 2;
    localparam int XL    = 64;
    localparam int IL    = 32;
    localparam int DEPTH = 16;
    localparam int STH   = 4;
    localparam int SLIM  = (STH * NL) / 4;

    logic                 clock;
    logic                 reset_n;
    logic [63:0]          cyc;
    logic [NL-1:0]        tr_valid, tr_exception, tr_interrupt, tr_has_wdata;
    logic [NL*XL-1:0]     tr_iaddr, tr_cause, tr_wdata;
    logic [NL*IL-1:0]     tr_insn;
    logic [NL*3-1:0]      tr_priv;
    logic                 out_valid, out_ready, stall_req, overflow;
    logic [REC_W-1:0]     out_rec;
    logic [31:0]          drop_count;
    trace_rec_t           hd;

    assign hd = out_rec;

    cosim_trace_serializer #(
        .NLANES(NL), .XLEN(XL), .ILEN(IL), .DEPTH(DEPTH), .STALL_TH(STH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cycle(cyc),
        .tr_valid(tr_valid), .tr_exception(tr_exception), .tr_interrupt(tr_interrupt),
        .tr_has_wdata(tr_has_wdata), .tr_iaddr(tr_iaddr), .tr_insn(tr_insn),
        .tr_cause(tr_cause), .tr_wdata(tr_wdata), .tr_priv(tr_priv),
        .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
        .stall_req(stall_req), .overflow(overflow), .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    trace_rec_t  mq[$];
    int unsigned m_drops;
    bit          m_ovf;

    task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    function automatic bit lane_act(input int i);
        return tr_valid[i] | tr_exception[i] | (tr_cause[i*XL +: XL] != '0);
    endfunction

    function automatic trace_rec_t make_rec(input int i);
        trace_rec_t r;
        r.cycle     = cyc;
        r.lane      = 3'(i);
        r.iaddr     = tr_iaddr[i*XL +: XL];
        r.insn      = tr_insn[i*IL +: IL];
        r.exception = tr_exception[i];
        r.interrupt = tr_interrupt[i];
        r.cause     = tr_cause[i*XL +: XL];
        r.has_wdata = tr_has_wdata[i];
        r.wdata     = tr_wdata[i*XL +: XL];
        r.priv      = tr_priv[i*3 +: 3];
        return r;
    endfunction

    // Reference model: a queue of records, all-or-nothing groups sized against the pre-edge occupancy.
    always @(posedge clock or negedge reset_n) begin : model
        int     n;
        bit     pop_m;
        longint s;
        if (!reset_n) begin
            mq.delete();
            m_drops = 0;
            m_ovf   = 0;
        end else begin
            n = 0;
            for (int i = 0; i < NL; i++) if (lane_act(i)) n++;
            pop_m = (mq.size() != 0) && out_ready;
            if (n != 0 && n <= DEPTH - mq.size()) begin
                if (pop_m) void'(mq.pop_front());
                for (int i = 0; i < NL; i++) if (lane_act(i)) mq.push_back(make_rec(i));
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (n != 0) begin
                    m_ovf = 1;
                    s = longint'(m_drops) + n;
                    m_drops = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        chk("out_valid", 512'(out_valid), 512'(mq.size() != 0));
        if (mq.size() != 0) chk("out_rec", 512'(out_rec), 512'(mq[0]));
        chk("stall_req", 512'(stall_req), 512'((DEPTH - mq.size()) < SLIM));
        chk("overflow", 512'(overflow), 512'(m_ovf));
        chk("drop_count", 512'(drop_count), 512'(m_drops));
    end

    task automatic tick();
        @(negedge clock);
        cyc = cyc + 1;
    endtask

    task automatic set_lane(input int i, input bit v, input bit e, input logic [63:0] c);
        tr_valid[i]             = v;
        tr_exception[i]         = e;
        tr_cause[i*XL +: XL]    = c;
        tr_interrupt[i]         = 1'($urandom);
        tr_has_wdata[i]         = 1'($urandom);
        tr_iaddr[i*XL +: XL]    = {$urandom, $urandom};
        tr_wdata[i*XL +: XL]    = {$urandom, $urandom};
        tr_insn[i*IL +: IL]     = $urandom;
        tr_priv[i*3 +: 3]       = ($urandom_range(0, 2) == 0) ? PRIV_U :
                                  ($urandom_range(0, 1) == 0) ? PRIV_S : PRIV_M;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) set_lane(i, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic rand_lane(input int i);
        case ($urandom_range(0, 3))
            0: set_lane(i, 1'b0, 1'b0, 64'd0);
            1: set_lane(i, 1'b1, 1'b0, 64'd0);
            2: set_lane(i, 1'($urandom), 1'b1, 64'($urandom_range(1, 15)));
            default: set_lane(i, 1'b0, 1'b0, 64'($urandom_range(1, 15)));
        endcase
    endtask

    initial begin : stim
        int pushed;
        int guard;
        reset_n   = 1'b1;
        out_ready = 1'b0;
        cyc       = 64'd0;
        for (int i = 0; i < NL; i++) set_lane(i, 1'b1, 1'b0, 64'd0);
        #1 reset_n = 1'b0;

        // Reset held with every lane retiring: nothing may be captured.
        repeat (3) tick();
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_drop_count", 512'(drop_count), 512'(0));
        clear_lanes();
        reset_n = 1'b1;
        tick();
        chk("rst_nothing_stored", 512'(out_valid), 512'(0));

        // Compaction: lone lane 1, then both lanes in lane order.
        set_lane(1, 1'b1, 1'b0, 64'd0);
        tr_iaddr[XL +: XL] = 64'h8000_0004;
        cyc = 64'd100;
        tick();
        chk("cmp_valid", 512'(out_valid), 512'(1));
        chk("cmp_lane", 512'(hd.lane), 512'(1));
        chk("cmp_cycle", 512'(hd.cycle), 512'(100));
        chk("cmp_iaddr", 512'(hd.iaddr), 512'(64'h8000_0004));
        set_lane(0, 1'b1, 1'b0, 64'd0);
        set_lane(1, 1'b1, 1'b0, 64'd0);
        tick();
        clear_lanes();
        out_ready = 1'b1;
        tick();
        chk("cmp_second_lane", 512'(hd.lane), 512'(0));
        chk("cmp_second_cycle", 512'(hd.cycle), 512'(101));
        tick();
        chk("cmp_third_lane", 512'(hd.lane), 512'(1));
        tick();
        chk("cmp_drained", 512'(out_valid), 512'(0));

        // Trap-only lane.
        out_ready = 1'b0;
        set_lane(0, 1'b0, 1'b1, 64'd2);
        tick();
        chk("trap_valid", 512'(out_valid), 512'(1));
        chk("trap_exc", 512'(hd.exception), 512'(1));
        chk("trap_cause", 512'(hd.cause), 512'(2));
        clear_lanes();
        out_ready = 1'b1;
        tick();

        // Fill to DEPTH, then the ninth group is dropped whole.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_lane(0, 1'b1, 1'b0, 64'd0);
            set_lane(1, 1'b1, 1'b0, 64'd0);
            tick();
            if (k == 6) chk("full_stall_at14", 512'(stall_req), 512'(0));
        end
        chk("full_model_count", 512'(mq.size()), 512'(16));
        chk("full_stall", 512'(stall_req), 512'(1));
        chk("full_no_drop_yet", 512'(drop_count), 512'(0));
        tick();
        chk("full_drop_count", 512'(drop_count), 512'(2));
        chk("full_overflow", 512'(overflow), 512'(1));

        // Simultaneous push/pop at count 15.
        clear_lanes();
        out_ready = 1'b1;
        tick();
        chk("sim_count15", 512'(mq.size()), 512'(15));
        set_lane(0, 1'b1, 1'b0, 64'd0);
        tick();
        chk("sim_one_accepted", 512'(mq.size()), 512'(15));
        chk("sim_one_no_drop", 512'(drop_count), 512'(2));
        set_lane(0, 1'b1, 1'b0, 64'd0);
        set_lane(1, 1'b1, 1'b0, 64'd0);
        tick();
        chk("sim_two_dropped", 512'(drop_count), 512'(4));
        chk("sim_count14", 512'(mq.size()), 512'(14));
        chk("sim_stall_low", 512'(stall_req), 512'(0));

        // Reset mid-drain: out_valid must fall without waiting for a clock.
        clear_lanes();
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("mid_reset_valid", 512'(out_valid), 512'(0));
        chk("mid_reset_drops", 512'(drop_count), 512'(0));
        tick();
        reset_n = 1'b1;
        tick();

        // 40 single-lane records with random consumer readiness, across pointer wrap.
        pushed = 0;
        guard  = 0;
        while (pushed < 40 && guard < 1000) begin
            clear_lanes();
            out_ready = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                set_lane(int'($urandom_range(0, NL - 1)), 1'b1, 1'b0, 64'd0);
                pushed++;
            end
            tick();
            guard++;
        end
        chk("wrap_budget", 512'(guard < 1000), 512'(1));

        // Mixed random traffic with a slow consumer to provoke drops.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NL; i++) rand_lane(i);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        clear_lanes();
        out_ready = 1'b1;
        guard = 0;
        while (out_valid && guard < 64) begin
            tick();
            guard++;
        end
        chk("final_drain", 512'(out_valid), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
